// File: rtl/range_pkg.sv
// Shared types and helpers for the range tracker slice.
package range_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // All-ones value of a counter of the given width.
    function automatic longint unsigned cnt_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/range_cmp.sv
// Folds one sample into a running min/max pair, signed or unsigned.
module range_cmp #(
    parameter int unsigned WIDTH  = 10,
    parameter bit          SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] cur_min,
    input  logic [WIDTH-1:0] cur_max,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] new_min,
    output logic [WIDTH-1:0] new_max
);

    logic below_min;
    logic above_max;

    always_comb begin
        below_min = 1'b0;
        above_max = 1'b0;
        if (SIGNED) begin
            below_min = $signed(sample) < $signed(cur_min);
            above_max = $signed(sample) > $signed(cur_max);
        end else begin
            below_min = sample < cur_min;
            above_max = sample > cur_max;
        end
        new_min = below_min ? sample : cur_min;
        new_max = above_max ? sample : cur_max;
    end

endmodule

// File: rtl/range_tracker.sv
// Tracks min, max, range and sample count of data_in over a go..finish window;
// results are held in output registers until the next window completes.
module range_tracker
    import range_pkg::*;
#(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned CNT_WIDTH = 8,
    parameter bit          SIGNED    = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 go,
    input  logic                 finish,
    output logic [WIDTH-1:0]     range,
    output logic [WIDTH-1:0]     min_out,
    output logic [WIDTH-1:0]     max_out,
    output logic [CNT_WIDTH-1:0] count_out,
    output logic                 done,
    output logic                 error,
    output logic                 overflow
);

    localparam logic [CNT_WIDTH-1:0] CMAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

    state_t               state;
    logic [WIDTH-1:0]     cur_min;
    logic [WIDTH-1:0]     cur_max;
    logic [CNT_WIDTH-1:0] cur_cnt;
    logic                 cur_sat;

    logic [WIDTH-1:0]     new_min;
    logic [WIDTH-1:0]     new_max;
    logic [CNT_WIDTH-1:0] nxt_cnt;
    logic                 nxt_sat;

    range_cmp #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_cmp (
        .cur_min (cur_min),
        .cur_max (cur_max),
        .sample  (data_in),
        .new_min (new_min),
        .new_max (new_max)
    );

    // Overflow means a sample arrived while the counter was already pinned.
    always_comb begin
        nxt_cnt = (cur_cnt == CMAX) ? cur_cnt : cur_cnt + CNT_WIDTH'(1);
        nxt_sat = cur_sat | (cur_cnt == CMAX);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_min   <= '0;
            cur_max   <= '0;
            cur_cnt   <= '0;
            cur_sat   <= 1'b0;
            range     <= '0;
            min_out   <= '0;
            max_out   <= '0;
            count_out <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (finish) begin
                        error <= 1'b1;
                    end else if (go) begin
                        cur_min <= data_in;
                        cur_max <= data_in;
                        cur_cnt <= CNT_WIDTH'(1);
                        cur_sat <= 1'b0;
                        error   <= 1'b0;
                        state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (go) begin
                        error <= 1'b1;
                    end
                    cur_min <= new_min;
                    cur_max <= new_max;
                    cur_cnt <= nxt_cnt;
                    cur_sat <= nxt_sat;
                    if (finish) begin
                        min_out   <= new_min;
                        max_out   <= new_max;
                        range     <= new_max - new_min;
                        count_out <= nxt_cnt;
                        overflow  <= nxt_sat;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_range_tracker.sv
// Directed bench: unsigned, signed and 3-bit-counter instances of range_tracker.
module tb_range_tracker;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] go_v  = '0;
    logic [2:0] fin_v = '0;
    logic [9:0] din_v [3];
    logic [9:0] rng   [3];
    logic [9:0] mn    [3];
    logic [9:0] mx    [3];
    logic [7:0] cnt   [3];
    logic [2:0] cnt_s;
    logic [2:0] done_v;
    logic [2:0] err_v;
    logic [2:0] ovf_v;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign cnt[2] = {5'b0, cnt_s};

    range_tracker #(.WIDTH(10), .CNT_WIDTH(8), .SIGNED(1'b0)) u_uns (
        .clock(clock), .reset(reset), .data_in(din_v[0]), .go(go_v[0]), .finish(fin_v[0]),
        .range(rng[0]), .min_out(mn[0]), .max_out(mx[0]), .count_out(cnt[0]),
        .done(done_v[0]), .error(err_v[0]), .overflow(ovf_v[0])
    );

    range_tracker #(.WIDTH(10), .CNT_WIDTH(8), .SIGNED(1'b1)) u_sgn (
        .clock(clock), .reset(reset), .data_in(din_v[1]), .go(go_v[1]), .finish(fin_v[1]),
        .range(rng[1]), .min_out(mn[1]), .max_out(mx[1]), .count_out(cnt[1]),
        .done(done_v[1]), .error(err_v[1]), .overflow(ovf_v[1])
    );

    range_tracker #(.WIDTH(10), .CNT_WIDTH(3), .SIGNED(1'b0)) u_sat (
        .clock(clock), .reset(reset), .data_in(din_v[2]), .go(go_v[2]), .finish(fin_v[2]),
        .range(rng[2]), .min_out(mn[2]), .max_out(mx[2]), .count_out(cnt_s),
        .done(done_v[2]), .error(err_v[2]), .overflow(ovf_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int k, input logic g, input logic f, input logic [9:0] d);
        @(negedge clock);
        go_v[k]  = g;
        fin_v[k] = f;
        din_v[k] = d;
    endtask

    // Called right after the finish cycle's edge: expects the done pulse and
    // the latched results, then confirms done drops one cycle later.
    task automatic expect_result(input string tag, input int k, input logic [9:0] emin,
                                 input logic [9:0] emax, input logic [9:0] erng,
                                 input logic [7:0] ecnt, input logic eovf, input logic eerr);
        drive(k, 1'b0, 1'b0, 10'd0);
        check({tag, " done"},  32'(done_v[k]), 32'd1);
        check({tag, " min"},   32'(mn[k]),     32'(emin));
        check({tag, " max"},   32'(mx[k]),     32'(emax));
        check({tag, " range"}, 32'(rng[k]),    32'(erng));
        check({tag, " count"}, 32'(cnt[k]),    32'(ecnt));
        check({tag, " ovf"},   32'(ovf_v[k]),  32'(eovf));
        check({tag, " err"},   32'(err_v[k]),  32'(eerr));
        drive(k, 1'b0, 1'b0, 10'd0);
        check({tag, " done drop"}, 32'(done_v[k]), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) din_v[i] = '0;
        #12;
        for (int i = 0; i < 3; i++) begin
            check("reset min",   32'(mn[i]),    32'd0);
            check("reset range", 32'(rng[i]),   32'd0);
            check("reset count", 32'(cnt[i]),   32'd0);
            check("reset done",  32'(done_v[i]), 32'd0);
            check("reset err",   32'(err_v[i]), 32'd0);
            check("reset ovf",   32'(ovf_v[i]), 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;

        // Unsigned basic window.
        drive(0, 1'b1, 1'b0, 10'd100);
        drive(0, 1'b0, 1'b0, 10'd40);
        drive(0, 1'b0, 1'b0, 10'd900);
        drive(0, 1'b0, 1'b1, 10'd300);
        expect_result("uns", 0, 10'd40, 10'd900, 10'd860, 8'd4, 1'b0, 1'b0);

        // Signed window: -5, 12, -512.
        drive(1, 1'b1, 1'b0, 10'h3FB);
        drive(1, 1'b0, 1'b0, 10'd12);
        drive(1, 1'b0, 1'b1, 10'h200);
        expect_result("sgn", 1, 10'h200, 10'd12, 10'd524, 8'd3, 1'b0, 1'b0);

        // finish in IDLE: error, no done, outputs held.
        drive(0, 1'b0, 1'b1, 10'd5);
        drive(0, 1'b0, 1'b0, 10'd0);
        check("idle fin err",  32'(err_v[0]),  32'd1);
        check("idle fin done", 32'(done_v[0]), 32'd0);
        check("idle fin min",  32'(mn[0]),     32'd40);
        check("idle fin cnt",  32'(cnt[0]),    32'd4);

        // Valid go clears error; go during ACTIVE sets it, window still completes.
        drive(0, 1'b1, 1'b0, 10'd5);
        drive(0, 1'b1, 1'b0, 10'd7);
        check("go clears err", 32'(err_v[0]), 32'd0);
        drive(0, 1'b0, 1'b1, 10'd3);
        check("active go err", 32'(err_v[0]), 32'd1);
        expect_result("actgo", 0, 10'd3, 10'd7, 10'd4, 8'd3, 1'b0, 1'b1);

        // go+finish while ACTIVE: handled as finish, sample included.
        drive(0, 1'b1, 1'b0, 10'd50);
        drive(0, 1'b0, 1'b0, 10'd55);
        check("restart err", 32'(err_v[0]), 32'd0);
        drive(0, 1'b1, 1'b1, 10'd60);
        expect_result("gofin act", 0, 10'd50, 10'd60, 10'd10, 8'd3, 1'b0, 1'b1);
        // Back in IDLE: a lone finish must not produce done.
        drive(0, 1'b0, 1'b1, 10'd1);
        drive(0, 1'b0, 1'b0, 10'd0);
        check("gofin idle state", 32'(done_v[0]), 32'd0);

        // go+finish in IDLE on the signed unit (error currently clear).
        drive(1, 1'b1, 1'b1, 10'd9);
        drive(1, 1'b0, 1'b0, 10'd0);
        check("gofin idle err",  32'(err_v[1]),  32'd1);
        check("gofin idle done", 32'(done_v[1]), 32'd0);
        check("gofin idle min",  32'(mn[1]),     32'h200);
        drive(1, 1'b0, 1'b1, 10'd9);
        drive(1, 1'b0, 1'b0, 10'd0);
        check("gofin stayed idle", 32'(done_v[1]), 32'd0);

        // Saturation: 10 samples on a 3-bit counter.
        drive(2, 1'b1, 1'b0, 10'd5);
        for (int i = 1; i < 9; i++) drive(2, 1'b0, 1'b0, 10'(i * 10));
        drive(2, 1'b0, 1'b1, 10'd2);
        expect_result("sat", 2, 10'd2, 10'd80, 10'd78, 8'd7, 1'b1, 1'b0);
        drive(2, 1'b1, 1'b0, 10'd600);
        drive(2, 1'b0, 1'b0, 10'd601);
        drive(2, 1'b0, 1'b1, 10'd599);
        expect_result("nosat", 2, 10'd599, 10'd601, 10'd2, 8'd3, 1'b0, 1'b0);

        // Async reset mid-window.
        drive(0, 1'b1, 1'b0, 10'd10);
        drive(0, 1'b0, 1'b0, 10'd20);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("arst min",   32'(mn[0]),     32'd0);
        check("arst max",   32'(mx[0]),     32'd0);
        check("arst range", 32'(rng[0]),    32'd0);
        check("arst cnt",   32'(cnt[0]),    32'd0);
        check("arst err",   32'(err_v[0]),  32'd0);
        check("arst done",  32'(done_v[0]), 32'd0);
        check("arst sgn min", 32'(mn[1]),   32'd0);
        @(negedge clock);
        reset = 1'b0;
        drive(0, 1'b0, 1'b1, 10'd7);
        drive(0, 1'b0, 1'b0, 10'd0);
        check("arst abandoned", 32'(done_v[0]), 32'd0);
        drive(0, 1'b1, 1'b0, 10'd30);
        drive(0, 1'b0, 1'b1, 10'd8);
        expect_result("post rst", 0, 10'd8, 10'd30, 10'd22, 8'd2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/range_tracker.md
Name: range_tracker

Overview:
- Parametrised successor to the single-window range finder.
- Over a go..finish sampling window it tracks the minimum, maximum, range (max-min) and sample count of data_in.
- Supports signed or unsigned data and a saturating sample counter, with distinct error and overflow flags.
- Sits directly behind the chip I/O wrapper.
- Results are held in output registers until the next window completes.

Parameters:
- WIDTH, 10, data sample width in bits (>=2).
- CNT_WIDTH, 8, sample-counter width in bits (>=1).
- SIGNED, 0, 1 = data_in is two's complement; 0 = unsigned.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  sample; sampled every cycle the window is open, including the go cycle and the finish cycle.
- go  input  1  opens a window (level-sampled each cycle).
- finish  input  1  closes a window; its cycle's sample is included.
- range  output  WIDTH  max-min of the last completed window, always unsigned.
- min_out  output  WIDTH  minimum of the last window (interpreted per SIGNED).
- max_out  output  WIDTH  maximum of the last window.
- count_out  output  CNT_WIDTH  samples in the last window, saturating.
- done  output  1  one-cycle pulse on the cycle the results update.
- error  output  1  protocol-error flag (sticky, see below).
- overflow  output  1  the counter saturated in the last window.

Behaviour:
- Clock and reset:
  - One clock, named clock.
  - reset is asynchronous and active-high.
  - Reset state: FSM=IDLE; range, min_out, max_out and count_out = 0; done=0; error=0; overflow=0.
  - Internal running regs cur_min, cur_max and cur_cnt are cleared to 0.
- FSM states: IDLE, ACTIVE.
- IDLE, go=1, finish=0:
  - cur_min=cur_max=data_in, cur_cnt=1.
  - error cleared to 0, next state ACTIVE.
  - Output regs unchanged.
- IDLE, finish=1 (with or without go):
  - error <= 1, stay IDLE.
  - No running-reg or output update; done=0.
- IDLE, go=0, finish=0: hold.
- ACTIVE, finish=0:
  - cur_min=min(cur_min,data_in), cur_max=max(cur_max,data_in).
  - cur_cnt increments, saturating at 2^CNT_WIDTH-1.
  - If go=1: error <= 1, the sample is still folded in, and there is no restart.
- ACTIVE, finish=1:
  - The final sample is folded into the running values; call these nxt_min, nxt_max, nxt_cnt.
  - Output regs load from them: min_out=nxt_min, max_out=nxt_max, range=nxt_max-nxt_min (WIDTH bits, no wrap for either signedness), count_out=nxt_cnt.
  - overflow = the counter saturated at any point in the window, including on this sample.
  - done=1 for the next cycle only; next state IDLE.
  - If go=1 on the same cycle: error <= 1, handled as finish. The next window needs a fresh go in IDLE.
- Latency: outputs and done are visible the cycle after the finish edge.
- A single-cycle window (go then finish on the next cycle) yields count_out=2. A window cannot be shorter.
- Comparisons:
  - SIGNED=1: two's-complement comparison.
  - SIGNED=0: unsigned comparison.
  - range subtraction is modular WIDTH-bit; it is mathematically exact because max>=min.
- error is sticky: it is cleared only by reset or by a valid window start (go from IDLE without finish).
  - error does not stop an active window.
- reset mid-window: the window is abandoned immediately; no done pulse; outputs go to 0.
- overflow is held with the outputs; it updates only on window completion.

Decomposition:
- Package range_pkg:
  - state_t enum {IDLE, ACTIVE}.
  - Helper function cnt_max(CNT_WIDTH).
- Sub-module range_cmp (purely combinational, parametrised WIDTH and SIGNED):
  - Inputs: cur_min, cur_max, sample.
  - Outputs: new_min, new_max.
  - Instantiated once in range_tracker.
- The FSM, counter and output registers live in range_tracker.

Test Plan:
- Unsigned basic (WIDTH=10): go with 100, then 40, 900, then finish with 300 -> next cycle min_out=40, max_out=900, range=860, count_out=4, done pulse 1 cycle, error=0.
- Signed mode (SIGNED=1, WIDTH=10): go with -5 (0x3FB), then 12, then finish with -512 (0x200) -> min_out=0x200, max_out=12, range=524, count_out=3.
- Protocol errors:
  - finish in IDLE -> error=1, outputs unchanged, no done.
  - Then go in IDLE -> error=0.
  - go during ACTIVE -> error=1, and the window still completes with all samples counted.
- Counter saturation (CNT_WIDTH=3): 10-sample window -> count_out=7, overflow=1.
  - A following 3-sample window -> count_out=3, overflow=0.
- Simultaneous go and finish:
  - In IDLE -> error=1, stay IDLE, no done.
  - In ACTIVE -> results latched including that sample, error=1, FSM returns to IDLE.
- Async reset mid-window (asserted between edges after 2 samples) -> all outputs 0 immediately with no clock edge, no done.
  - A new window after reset release -> correct results.
